// File: rtl/vga_fb_scanout_if.sv
// Pixel-buffer read port and double-buffer swap handshake between the VGA scanout
// (master) and the rasterizer/buffer side (slave).
interface vga_fb_scanout_if;
   logic       fb_rd_en;
   logic [8:0] fb_rd_addr;
   logic       fb_rd_data;
   logic       fb_sel;
   logic       swap_req;
   logic       swap_ack;

   modport master (
      output fb_rd_en,
      output fb_rd_addr,
      output fb_sel,
      output swap_ack,
      input  fb_rd_data,
      input  swap_req
   );

   modport slave (
      input  fb_rd_en,
      input  fb_rd_addr,
      input  fb_sel,
      input  swap_ack,
      output fb_rd_data,
      output swap_req
   );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA timing generator that scans a BUF_W x BUF_H 1-bit buffer, upscaled by SCALE, with a
// 3-stage output pipeline and a frame-boundary double-buffer swap.
module vga_fb_scanout #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 33,
   parameter int unsigned BUF_W        = 20,
   parameter int unsigned BUF_H        = 20,
   parameter int unsigned SCALE        = 24,
   parameter int unsigned X_OFF        = 80,
   parameter logic [2:0]  FG_COLOR     = 3'b111,
   parameter logic [2:0]  BG_COLOR     = 3'b000,
   parameter logic [2:0]  BORDER_COLOR = 3'b001
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr_screen,
   vga_fb_scanout_if.master       fb,
   output logic                   frame_start,
   output logic [2:0]             pixel,
   output logic                   hsync_out,
   output logic                   vsync_out
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] X_START  = 10'(X_OFF);
   localparam logic [9:0] X_LAST   = 10'(X_OFF + BUF_W * SCALE - 1);
   localparam logic [9:0] Y_END    = 10'(BUF_H * SCALE);
   localparam logic [7:0] SC_LAST  = 8'(SCALE - 1);
   localparam logic [8:0] ROW_STEP = 9'(BUF_W);

   // Stage 0: raster counters and cell trackers
   logic [9:0] h_q, v_q;
   logic [7:0] sx_q, sy_q;
   logic [8:0] bx_q, row_base_q;

   logic in_h, in_v, in_region, active0, hs0, vs0, fs0, last0;

   always_comb begin
      in_h      = (h_q >= X_START) && (h_q <= X_LAST);
      in_v      = (v_q < Y_END);
      in_region = in_h && in_v;
      active0   = (h_q < H_ACT) && (v_q < V_ACT);
      hs0       = !((h_q >= HS_START) && (h_q < HS_END));
      vs0       = !((v_q >= VS_START) && (v_q < VS_END));
      fs0       = (h_q == 10'd0) && (v_q == 10'd0);
      last0     = (h_q == H_LAST) && (v_q == V_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_q <= 10'd0;
         v_q <= 10'd0;
      end else if (h_q == H_LAST) begin
         h_q <= 10'd0;
         v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
         h_q <= h_q + 10'd1;
      end
   end

   // bx/sx describe the cell under the current h_cnt; they idle at 0 outside the region
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sx_q <= 8'd0;
         bx_q <= 9'd0;
      end else if (!in_h || (h_q == X_LAST)) begin
         sx_q <= 8'd0;
         bx_q <= 9'd0;
      end else if (sx_q == SC_LAST) begin
         sx_q <= 8'd0;
         bx_q <= bx_q + 9'd1;
      end else begin
         sx_q <= sx_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sy_q       <= 8'd0;
         row_base_q <= 9'd0;
      end else if (h_q == H_LAST) begin
         if (v_q == V_LAST) begin
            sy_q       <= 8'd0;
            row_base_q <= 9'd0;
         end else if (in_v) begin
            if (sy_q == SC_LAST) begin
               sy_q       <= 8'd0;
               row_base_q <= row_base_q + ROW_STEP;
            end else begin
               sy_q <= sy_q + 8'd1;
            end
         end
      end
   end

   // Stage 1: buffer read request plus flags travelling alongside it
   logic       rd_en_q;
   logic [8:0] rd_addr_q;
   logic       act1_q, reg1_q, clr1_q, hs1_q, vs1_q, fs1_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= 9'd0;
         act1_q    <= 1'b0;
         reg1_q    <= 1'b0;
         clr1_q    <= 1'b0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         fs1_q     <= 1'b0;
      end else begin
         rd_en_q   <= in_region;
         rd_addr_q <= in_region ? (row_base_q + bx_q) : 9'd0;
         act1_q    <= active0;
         reg1_q    <= in_region;
         clr1_q    <= clr_screen;
         hs1_q     <= hs0;
         vs1_q     <= vs0;
         fs1_q     <= fs0;
      end
   end

   // Stage 2: buffer data arrives this cycle
   logic act2_q, reg2_q, clr2_q, hs2_q, vs2_q, fs2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act2_q <= 1'b0;
         reg2_q <= 1'b0;
         clr2_q <= 1'b0;
         hs2_q  <= 1'b1;
         vs2_q  <= 1'b1;
         fs2_q  <= 1'b0;
      end else begin
         act2_q <= act1_q;
         reg2_q <= reg1_q;
         clr2_q <= clr1_q;
         hs2_q  <= hs1_q;
         vs2_q  <= vs1_q;
         fs2_q  <= fs1_q;
      end
   end

   // Stage 3: registered outputs
   logic [2:0] pixel_d, pixel_q;
   logic       hsync_q, vsync_q, fs3_q;

   always_comb begin
      pixel_d = 3'b000;
      if (act2_q) begin
         if (!reg2_q) begin
            pixel_d = BORDER_COLOR;
         end else if (clr2_q || !fb.fb_rd_data) begin
            pixel_d = BG_COLOR;
         end else begin
            pixel_d = FG_COLOR;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_q <= 3'b000;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fs3_q   <= 1'b0;
      end else begin
         pixel_q <= pixel_d;
         hsync_q <= hs2_q;
         vsync_q <= vs2_q;
         fs3_q   <= fs2_q;
      end
   end

   // Swap only on the last counter cycle, so the displayed buffer is fixed for a whole frame
   logic sel_q, ack_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q <= 1'b0;
         ack_q <= 1'b0;
      end else if (last0 && fb.swap_req) begin
         sel_q <= ~sel_q;
         ack_q <= 1'b1;
      end else begin
         ack_q <= 1'b0;
      end
   end

   assign fb.fb_rd_en   = rd_en_q;
   assign fb.fb_rd_addr = rd_addr_q;
   assign fb.fb_sel     = sel_q;
   assign fb.swap_ack   = ack_q;
   assign frame_start   = fs3_q;
   assign pixel         = pixel_q;
   assign hsync_out     = hsync_q;
   assign vsync_out     = vsync_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Scoreboard bench for vga_fb_scanout on a reduced raster (98x67 totals, SCALE 3).
module tb_vga_fb_scanout;
   localparam int H_ACTIVE = 80, H_FP = 4, H_SYNC = 8, H_BP = 6;
   localparam int V_ACTIVE = 60, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int BUF_W = 20, BUF_H = 20, SCALE = 3, X_OFF = 10;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOTAL * V_TOTAL;
   localparam int CLR_LINE = 4;
   localparam logic [2:0] FG = 3'b111, BG = 3'b000, BORDER = 3'b001;

   typedef struct {logic [2:0] pix; logic hs; logic vs; logic fs;} out_t;
   typedef struct {logic en; int addr;} rd_t;
   typedef struct {logic sel; logic ack;} sw_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clr_screen;
   logic       frame_start, hsync_out, vsync_out;
   logic [2:0] pixel;

   vga_fb_scanout_if fb_if ();

   vga_fb_scanout #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .BUF_W(BUF_W), .BUF_H(BUF_H), .SCALE(SCALE), .X_OFF(X_OFF),
      .FG_COLOR(FG), .BG_COLOR(BG), .BORDER_COLOR(BORDER)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clr_screen(clr_screen),
      .fb(fb_if),
      .frame_start(frame_start),
      .pixel(pixel),
      .hsync_out(hsync_out),
      .vsync_out(vsync_out)
   );

   always #5 clk = ~clk;

   // Buffer 0 holds only cell 21; buffer 1 holds cells 0 and 399
   function automatic logic mem_bit(input logic sel, input int a);
      return sel ? ((a == 0) || (a == 399)) : (a == 21);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) fb_if.fb_rd_data <= 1'b0;
      else fb_if.fb_rd_data <= fb_if.fb_rd_en && mem_bit(fb_if.fb_sel, int'(fb_if.fb_rd_addr));
   end

   out_t q_out[$];
   rd_t  q_rd[$];
   sw_t  q_sw[$];
   int   m_h, m_v, n_cyc;
   logic exp_sel, exp_ack, clr_mode;
   int   total = 0, bad = 0;

   // Producer: at each posedge, log expectations for the counter value just sampled
   initial begin
      logic p_act, p_reg;
      int   p_addr;
      logic [2:0] p_pix;
      forever begin
         @(posedge clk);
         if (!reset) begin
            m_h = 0; m_v = 0; n_cyc = 0; exp_sel = 1'b0; exp_ack = 1'b0;
            q_out.delete(); q_rd.delete(); q_sw.delete();
         end else begin
            p_act  = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
            p_reg  = (m_v < BUF_H * SCALE) && (m_h >= X_OFF) && (m_h < X_OFF + BUF_W * SCALE);
            p_addr = p_reg ? (m_v / SCALE) * BUF_W + (m_h - X_OFF) / SCALE : 0;
            if (!p_act) p_pix = 3'b000;
            else if (!p_reg) p_pix = BORDER;
            else if (clr_screen) p_pix = BG;
            else if (mem_bit(exp_sel, p_addr)) p_pix = FG;
            else p_pix = BG;
            q_out.push_back('{pix: p_pix,
                              hs: !((m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC)),
                              vs: !((m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC)),
                              fs: (m_h == 0) && (m_v == 0)});
            q_rd.push_back('{en: p_reg, addr: p_addr});
            if ((m_h == H_TOTAL - 1) && (m_v == V_TOTAL - 1) && fb_if.swap_req) begin
               exp_sel = !exp_sel;
               exp_ack = 1'b1;
            end else begin
               exp_ack = 1'b0;
            end
            q_sw.push_back('{sel: exp_sel, ack: exp_ack});
            if (m_h == H_TOTAL - 1) begin
               m_h = 0;
               m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end else begin
               m_h = m_h + 1;
            end
            n_cyc = n_cyc + 1;
         end
      end
   end

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, n_cyc, got, want);
      end
   endtask

   // Monitor: reset values while in reset, otherwise pop and compare at each negedge
   initial begin
      out_t o;
      rd_t  r;
      sw_t  s;
      forever begin
         @(negedge clk or negedge reset);
         if (!reset) begin
            #1;
            chk("rst_pixel", int'(pixel), 0);
            chk("rst_hsync", int'(hsync_out), 1);
            chk("rst_vsync", int'(vsync_out), 1);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_rd_en", int'(fb_if.fb_rd_en), 0);
            chk("rst_rd_addr", int'(fb_if.fb_rd_addr), 0);
            chk("rst_fb_sel", int'(fb_if.fb_sel), 0);
            chk("rst_swap_ack", int'(fb_if.swap_ack), 0);
         end else begin
            if (q_rd.size() >= 1) begin
               r = q_rd.pop_front();
               chk("rd_en", int'(fb_if.fb_rd_en), int'(r.en));
               if (r.en) chk("rd_addr", int'(fb_if.fb_rd_addr), r.addr);
            end
            if (q_out.size() >= 3) begin
               o = q_out.pop_front();
               chk("pixel", int'(pixel), int'(o.pix));
               chk("hsync", int'(hsync_out), int'(o.hs));
               chk("vsync", int'(vsync_out), int'(o.vs));
               chk("frame_start", int'(frame_start), int'(o.fs));
            end
            if (q_sw.size() >= 1) begin
               s = q_sw.pop_front();
               chk("fb_sel", int'(fb_if.fb_sel), int'(s.sel));
               chk("swap_ack", int'(fb_if.swap_ack), int'(s.ack));
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      clr_screen = clr_mode && (m_v == CLR_LINE);
   endtask

   task automatic run_to(input int cyc);
      int guard = 0;
      while ((n_cyc < cyc) && (guard < 4 * FRAME)) begin
         step();
         guard++;
      end
   endtask

   task automatic wait_pos(input int h, input int v);
      int guard = 0;
      while (!((m_h == h) && (m_v == v)) && (guard < 2 * FRAME)) begin
         step();
         guard++;
      end
      if (guard >= 2 * FRAME) begin
         total++;
         bad++;
         $display("FAIL wait_pos h=%0d v=%0d not reached", h, v);
      end
   endtask

   initial begin
      clr_screen = 1'b0;
      clr_mode = 1'b0;
      fb_if.swap_req = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Request mid-frame 0 and hold across two frame ends: two swaps
      wait_pos(40, 30);
      fb_if.swap_req = 1'b1;
      run_to(2 * FRAME + 100);
      fb_if.swap_req = 1'b0;

      // Clear one line during frame 2 (buffer 0 again)
      clr_mode = 1'b1;
      run_to(3 * FRAME + 50);
      clr_mode = 1'b0;

      // Asynchronous reset mid-frame
      wait_pos(40, 30);
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Request rising exactly on the last frame cycle is honoured
      wait_pos(H_TOTAL - 1, V_TOTAL - 1);
      fb_if.swap_req = 1'b1;
      repeat (3) step();
      fb_if.swap_req = 1'b0;
      run_to(FRAME + FRAME / 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
